// File: rtl/transition_logger.sv
// Timestamped capture of detector change masks into a small FIFO, gated by a
// one-shot arm/trigger FSM and drained through a registered pop port.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | after reset; events ignored, only arm leaves
// ARMED   | buffer cleared; waiting for a trigger event (stored at ts=0)
// CAPTURE | ts counting; every qualified event stored with current ts
// DONE    | buffer filled once; events dropped, overflow flags loss
module transition_logger #(
    parameter int CH_WIDTH = 4,
    parameter int TS_WIDTH = 8,
    parameter int DEPTH    = 8,
    localparam int EW      = TS_WIDTH + CH_WIDTH,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = AW + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                arm,
    input  logic [CH_WIDTH-1:0] trig_mask,
    input  logic                evt_valid,
    input  logic [CH_WIDTH-1:0] evt_mask,
    input  logic                rd_en,
    output logic [EW-1:0]       rd_data,
    output logic                rd_valid,
    output logic [CW-1:0]       count,
    output logic [1:0]          state,
    output logic                overflow,
    output logic                done
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [EW-1:0]       mem [DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [TS_WIDTH-1:0] ts_q;

    logic          qualified, trig_hit, full, empty, pop, push, ovf_set;
    logic [EW-1:0] push_data;

    assign qualified = evt_valid & (|evt_mask);
    assign trig_hit  = qualified & ((trig_mask == '0) | (|(evt_mask & trig_mask)));
    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    // arm wins over a same-cycle pop so the cleared buffer is never read
    assign pop       = rd_en & ~empty & ~arm;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        push      = 1'b0;
        push_data = {ts_q, evt_mask};
        ovf_set   = 1'b0;
        if (arm) begin
            state_d = S_ARMED;
        end else begin
            case (state_q)
                S_ARMED: begin
                    if (trig_hit) begin
                        push      = 1'b1;
                        push_data = {TS_WIDTH'(0), evt_mask};
                        state_d   = S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (qualified && !full) begin
                        push = 1'b1;
                        // a concurrent pop keeps count below DEPTH
                        if (!pop && count == CW'(DEPTH - 1)) begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (qualified && full) begin
                        ovf_set = 1'b1;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            overflow <= 1'b0;
            ts_q     <= '0;
        end else if (arm) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
            overflow <= 1'b0;
            ts_q     <= '0;
        end else begin
            rd_valid <= pop;
            if (pop) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + AW'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (ovf_set) begin
                overflow <= 1'b1;
            end
            // trigger entry is ts 0, so the first capture cycle counts 1
            if (state_q == S_ARMED && trig_hit) begin
                ts_q <= TS_WIDTH'(1);
            end else if (state_q == S_CAPTURE && ts_q != '1) begin
                ts_q <= ts_q + TS_WIDTH'(1);
            end
        end
    end

    assign state = state_q;
    assign done  = (state_q == S_DONE);

endmodule

// File: tb/tb_transition_logger.sv
// Bench for transition_logger: directed scenarios plus random traffic, checked
// by a queue-based reference model and a scoreboard monitor on the falling edge.
module tb_transition_logger;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        arm = 1'b0;
    logic [3:0]  trig_mask = '0;
    logic        evt_valid = 1'b0;
    logic [3:0]  evt_mask = '0;
    logic        rd_en = 1'b0;
    logic [11:0] rd_data;
    logic        rd_valid;
    logic [3:0]  count;
    logic [1:0]  state;
    logic        overflow;
    logic        done;

    transition_logger dut (
        .clk(clk), .rst(rst), .arm(arm), .trig_mask(trig_mask),
        .evt_valid(evt_valid), .evt_mask(evt_mask), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .count(count),
        .state(state), .overflow(overflow), .done(done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit chk_en = 0;

    // reference model: buffer contents as a queue, state as plain integer
    int          m_st = 0;
    logic [11:0] m_q[$];
    int          m_ts = 0;
    bit          m_ovf = 0;
    bit          m_rv = 0;
    logic [11:0] m_rd = '0;
    logic [11:0] exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model();
        bit qual, trg;
        int sz0;
        if (rst) begin
            m_st = 0; m_q.delete(); m_ts = 0; m_ovf = 0; m_rv = 0; m_rd = '0;
            return;
        end
        if (arm) begin
            m_st = 1; m_q.delete(); m_ts = 0; m_ovf = 0; m_rv = 0;
            return;
        end
        qual = evt_valid && evt_mask != 0;
        trg  = qual && (trig_mask == 0 || (evt_mask & trig_mask) != 0);
        sz0  = m_q.size();
        m_rv = 0;
        if (rd_en && sz0 > 0) begin
            m_rd = m_q.pop_front();
            exp_q.push_back(m_rd);
            m_rv = 1;
        end
        case (m_st)
            1: if (trg) begin
                m_q.push_back({8'h00, evt_mask});
                m_st = 2;
                m_ts = 1;
            end
            2: begin
                if (qual) begin
                    m_q.push_back({8'(m_ts), evt_mask});
                    if (m_q.size() == 8) m_st = 3;
                end
                m_ts = (m_ts < 255) ? m_ts + 1 : 255;
            end
            3: if (qual && sz0 == 8) m_ovf = 1;
            default: ;
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        model();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rd_valid", rd_valid, m_rv);
            chk("rd_data_hold", rd_data, m_rd);
            chk("count", count, m_q.size());
            chk("state", state, m_st);
            chk("overflow", overflow, m_ovf);
            chk("done", done, m_st == 3);
            if (rd_valid) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_pop", 1, 0);
                end else begin
                    chk("sb_rd_data", rd_data, exp_q.pop_front());
                end
            end
        end
    end

    task automatic set_evt(input bit v, input logic [3:0] m);
        evt_valid = v;
        evt_mask  = m;
    endtask

    initial begin
        // reset, then an event in IDLE must be ignored
        rst = 1; step(); chk_en = 1; step();
        rst = 0;
        set_evt(1, 4'b0001); step();
        set_evt(0, 0); step();
        chk("idle_count", count, 0);
        chk("idle_state", state, 0);

        // trigger filtering
        arm = 1; step(); arm = 0;
        trig_mask = 4'b0100;
        set_evt(1, 4'b0001); step();
        set_evt(0, 0); step(); step();
        set_evt(1, 4'b0110); step();
        set_evt(0, 0); step();
        set_evt(1, 4'b1000); step();
        set_evt(0, 0); step();
        chk("filt_count", count, 2);
        chk("filt_state", state, 2);

        // fill to DEPTH and overflow
        arm = 1; step(); arm = 0;
        trig_mask = 4'b0000;
        for (int i = 0; i < 9; i++) begin
            set_evt(1, 4'b0010); step();
        end
        set_evt(0, 0); step();
        chk("fill_state", state, 3);
        chk("fill_done", done, 1);
        chk("fill_ovf", overflow, 1);

        // readout latency and order
        for (int i = 0; i < 9; i++) begin
            logic [11:0] e;
            e = {8'(i), 4'h2};
            rd_en = 1; step();
            chk("rdo_valid", rd_valid, i < 8);
            if (i < 8) chk("rdo_data", rd_data, e);
        end
        rd_en = 0; step();
        chk("rdo_count", count, 0);
        chk("rdo_valid_idle", rd_valid, 0);

        // timestamp saturation with simultaneous write and pop
        arm = 1; step(); arm = 0;
        set_evt(1, 4'b0001); step();
        set_evt(0, 0);
        repeat (300) step();
        set_evt(1, 4'b1111); rd_en = 1; step();
        set_evt(0, 0);
        chk("sat_pop_valid", rd_valid, 1);
        chk("sat_pop_data", rd_data, 12'h001);
        chk("sat_count", count, 1);
        step();
        rd_en = 0;
        chk("sat_entry", rd_data, 12'hFFF);
        step();

        // re-arm mid-capture with a same-cycle event
        arm = 1; step(); arm = 0;
        set_evt(1, 4'b0001); step();
        set_evt(1, 4'b0010); step();
        set_evt(1, 4'b0100); step();
        chk("rearm_pre_count", count, 3);
        arm = 1; set_evt(1, 4'b1000); step();
        arm = 0; set_evt(0, 0);
        chk("rearm_count", count, 0);
        chk("rearm_state", state, 1);
        chk("rearm_ovf", overflow, 0);
        step();
        chk("rearm_not_stored", count, 0);

        // random traffic
        for (int seg = 0; seg < 6; seg++) begin
            int rd_pct;
            rd_pct = (seg % 3 == 0) ? 10 : (seg % 3 == 1) ? 40 : 80;
            for (int c = 0; c < 500; c++) begin
                rst = ($urandom_range(0, 299) == 0);
                arm = ($urandom_range(0, 79) == 0);
                if ($urandom_range(0, 49) == 0)
                    trig_mask = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
                set_evt($urandom_range(0, 99) < 50, 4'($urandom_range(0, 15)));
                rd_en = ($urandom_range(0, 99) < rd_pct);
                step();
            end
        end
        rst = 0; arm = 0; rd_en = 0; set_evt(0, 0);
        step(); step();
        chk("sb_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/transition_logger.md
Name: transition_logger

Overview:
- Capture stage directly downstream of the per-channel transition detector.
- Takes each nonzero 4-bit change mask, stamps it with the cycle offset from a trigger event, and stores {timestamp, mask} in a small FIFO.
- Host/readout logic drains the FIFO through a pop interface with registered data.
- A 4-state arm/trigger FSM controls when capture starts and stops.

Parameters:
CH_WIDTH, 4, channel count; width of event and trigger masks
TS_WIDTH, 8, timestamp width in bits; saturating
DEPTH, 8, FIFO entries; power of two, at least 2
(entry width EW = TS_WIDTH + CH_WIDTH = 12 at defaults)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous active-high reset
arm  input  1  single-cycle pulse; clears buffer and enters ARMED
trig_mask  input  CH_WIDTH  channels whose transition fires trigger; 0 = any channel
evt_valid  input  1  evt_mask valid this cycle
evt_mask  input  CH_WIDTH  per-channel transition mask from detector
rd_en  input  1  pop request
rd_data  output  EW  popped entry {ts[TS_WIDTH-1:0], mask[CH_WIDTH-1:0]}, registered
rd_valid  output  1  one-cycle pulse, rd_data valid
count  output  log2(DEPTH)+1  entries currently stored
state  output  2  IDLE=0, ARMED=1, CAPTURE=2, DONE=3
overflow  output  1  sticky; an event was dropped because buffer full
done  output  1  high while state==DONE

Behaviour:
- Reset (rst high at clk edge): state=IDLE; count, rd_data, rd_valid, overflow, done, ts counter, FIFO pointers = 0. rst overrides every other input, including mid-capture.
- Qualified event: evt_valid=1 and evt_mask!=0. Trigger event: qualified and ((evt_mask & trig_mask)!=0, or trig_mask==0).
- arm: in any state, next state=ARMED; FIFO emptied (count=0), overflow=0, ts=0. arm beats a same-cycle rd_en (no pop, rd_valid=0) and any same-cycle event (not stored).
- IDLE: events ignored; only arm leaves.
- ARMED: non-trigger events ignored.
  - Trigger event: write {0, evt_mask}; state to CAPTURE; ts counter=1 next cycle.
- CAPTURE:
  - ts counter increments every cycle, saturating at 2^TS_WIDTH-1 (no wrap).
  - Each qualified event writes {ts, evt_mask} using the current-cycle ts value.
  - When a write makes count reach DEPTH (count after that write = DEPTH), state=DONE next cycle.
- DONE: done=1; qualified events not stored; overflow set to 1 by any qualified event while count==DEPTH; stays until arm/rst.
- Pop:
  - rd_en with count>0 (any state, arm low): oldest entry to rd_data, rd_valid=1 on the following cycle (1-cycle latency); count decrements.
  - rd_en when count==0: ignored, rd_valid=0, rd_data holds its last value.
  - rd_valid is never high two cycles unless rd_en was high on consecutive cycles with data available.
- Simultaneous write and pop in CAPTURE: both performed; count unchanged; a full condition cannot arise that cycle.
- Pops in DONE reduce count but do not return to CAPTURE; capture is one-shot per arm.
- Pointers wrap modulo DEPTH; count distinguishes full from empty.
- Trigger event in ARMED with a same-cycle rd_en: FIFO is empty, so the pop is ignored and the write is performed.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, evt_valid=1 mask=4'b0001 in IDLE -> count=0, state=0, rd_valid=0, overflow=0.
- Trigger filtering:
  - Stimulus: arm; trig_mask=4'b0100; event 4'b0001 at t0, event 4'b0110 at t0+3, event 4'b1000 at t0+5.
  - Response: first event ignored; entries {0x00,0x6} and {0x02,0x8}; count=2; state=2.
- Fill and overflow (DEPTH=8):
  - Stimulus: trig_mask=0; 9 consecutive events mask=4'b0010.
  - Response: entries ts 0..7; state=3 and done=1 after the 8th write; 9th dropped; overflow=1.
- Readout latency:
  - Stimulus: after the fill test, rd_en for 9 cycles.
  - Response: rd_valid pulses 8 times, each 1 cycle after rd_en; rd_data=0x002,0x012,...,0x072; the 9th rd_en gives rd_valid=0; count=0.
- Saturation and simultaneous ops:
  - Stimulus: trigger, then 300 idle cycles, then an event 4'b1111 with rd_en high in the same cycle.
  - Response: rd_valid pulse returns {0x00,0x?} (the trigger entry); new entry ts=0xFF; count stays 1.
- Re-arm mid-capture: arm while count=3 in CAPTURE, with an event the same cycle -> count=0, state=1, event not stored, overflow=0.
